// File: rtl/fifo_sched_pkg.sv
// Shared types and default sizing for the FIFO burst reader.
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    localparam int DEF_DSIZE   = 11;
    localparam int DEF_BURST   = 4;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/burst_timeout_ctr.sv
// Idle-cycle counter that flags when a partial burst has waited TIMEOUT cycles.
module burst_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_count,
    output logic o_hit
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == CW'(TIMEOUT - 1));
    assign o_hit  = i_count & ~i_clr & w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_count)
            r_count <= w_last ? '0 : r_count + CW'(1);
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Gathers BURST words from a FIFO read port (1-cycle read latency) into a packed burst.
// Define FIFO_BURST_TIMEOUT_EN to flush partial bursts after TIMEOUT idle cycles.
module fifo_burst_reader
    import fifo_sched_pkg::*;
#(
    parameter int DSIZE   = DEF_DSIZE,
    parameter int BURST   = DEF_BURST,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                         rclk,
    input  logic                         rrst_n,
    input  logic                         enable,
    input  logic                         rempty,
    output logic                         rreq,
    input  logic [DSIZE-1:0]             rdata,
    output logic [BURST*DSIZE-1:0]       burst_data,
    output logic [$clog2(BURST+1)-1:0]   burst_cnt,
    output logic                         burst_valid,
    input  logic                         burst_ready,
    output logic [15:0]                  words_read,
    output logic                         busy
);

    localparam int CW = $clog2(BURST + 1);

    if (BURST < 2 || TIMEOUT < 2) begin : g_param_chk
        $error("fifo_burst_reader: BURST and TIMEOUT must be >= 2");
    end

    state_e          r_state;
    state_e          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_pending;
    logic [15:0]     r_words;

    logic            w_capture;
    logic            w_handshake;
    logic            w_full;
    logic            w_room;
    logic            w_flush;
    logic [CW:0]     w_inflight;

    assign w_capture   = r_pending;
    assign w_handshake = (r_state == ST_EMIT) & burst_ready;
    assign w_full      = (r_cnt == CW'(BURST));
    // Words already captured plus the one in flight must leave space for another.
    assign w_inflight  = {1'b0, r_cnt} + {{CW{1'b0}}, r_pending};
    assign w_room      = (w_inflight < (CW+1)'(BURST));

`ifdef FIFO_BURST_TIMEOUT_EN
    logic w_tmo_clr;
    logic w_tmo_count;

    assign w_tmo_clr   = w_capture | (r_state != ST_FILL);
    assign w_tmo_count = (r_state == ST_FILL) & (r_cnt != '0) & ~r_pending;

    burst_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk   (rclk),
        .i_rst_n (rrst_n),
        .i_clr   (w_tmo_clr),
        .i_count (w_tmo_count),
        .o_hit   (w_flush)
    );
`else
    assign w_flush = 1'b0;
`endif

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (enable) w_next = ST_FILL;
            ST_FILL: begin
                if (w_full || w_flush)
                    w_next = ST_EMIT;
                else if (!enable && r_cnt == '0 && !r_pending)
                    w_next = ST_IDLE;
            end
            ST_EMIT: if (w_handshake) w_next = enable ? ST_FILL : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // The flush cycle blocks new reads so EMIT is never entered with a read in flight.
    always_comb begin
        rreq        = (r_state == ST_FILL) & enable & ~rempty & w_room & ~w_flush;
        burst_valid = (r_state == ST_EMIT);
        busy        = (r_state != ST_IDLE) | r_pending;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_pending <= 1'b0;
            r_cnt     <= '0;
            r_words   <= '0;
        end else begin
            r_pending <= rreq;
            if (w_capture) begin
                r_cnt   <= r_cnt + CW'(1);
                r_words <= r_words + 16'd1;
            end else if (w_handshake) begin
                r_cnt   <= '0;
            end
        end
    end

    for (genvar l = 0; l < BURST; l++) begin : g_lane
        logic [DSIZE-1:0] r_lane;

        always_ff @(posedge rclk or negedge rrst_n) begin
            if (!rrst_n)
                r_lane <= '0;
            else if (w_handshake)
                r_lane <= '0;
            else if (w_capture && r_cnt == CW'(l))
                r_lane <= rdata;
        end

        assign burst_data[l*DSIZE +: DSIZE] = r_lane;
    end

    assign burst_cnt  = r_cnt;
    assign words_read = r_words;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader; FIFO model answers rreq with data one cycle later.
module tb_fifo_burst_reader;

    localparam int DSIZE   = 11;
    localparam int BURST   = 4;
    localparam int TIMEOUT = 64;
    localparam int CW      = $clog2(BURST + 1);

    logic                   rclk = 1'b0;
    logic                   rrst_n = 1'b0;
    logic                   enable = 1'b0;
    logic                   rempty = 1'b1;
    logic                   rreq;
    logic [DSIZE-1:0]       rdata = '0;
    logic [BURST*DSIZE-1:0] burst_data;
    logic [CW-1:0]          burst_cnt;
    logic                   burst_valid;
    logic                   burst_ready = 1'b0;
    logic [15:0]            words_read;
    logic                   busy;

    typedef struct {
        logic [BURST*DSIZE-1:0] data;
        logic [CW-1:0]          cnt;
    } burst_t;

    logic [DSIZE-1:0] fifo_q[$];
    logic [DSIZE-1:0] stage[$];
    burst_t           exp_q[$];
    logic             empty_mask = 1'b0;
    logic             req_seen = 1'b0;
    logic             prev_hold = 1'b0;
    logic [BURST*DSIZE-1:0] prev_data = '0;
    int               n_chk = 0;
    int               n_fail = 0;
    int               rreq_cnt = 0;
    int               valid_cnt = 0;
    int               words_exp = 0;

    fifo_burst_reader #(
        .DSIZE   (DSIZE),
        .BURST   (BURST),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .enable      (enable),
        .rempty      (rempty),
        .rreq        (rreq),
        .rdata       (rdata),
        .burst_data  (burst_data),
        .burst_cnt   (burst_cnt),
        .burst_valid (burst_valid),
        .burst_ready (burst_ready),
        .words_read  (words_read),
        .busy        (busy)
    );

    always #5 rclk = ~rclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        rempty = (fifo_q.size() == 0) || empty_mask;
    endtask

    task automatic push_exp(input int n);
        burst_t b;
        b.data = '0;
        for (int k = 0; k < n; k++) b.data[k*DSIZE +: DSIZE] = stage[k];
        b.cnt = CW'(n);
        exp_q.push_back(b);
        stage.delete();
    endtask

    task automatic push_word(input logic [DSIZE-1:0] w);
        fifo_q.push_back(w);
        stage.push_back(w);
        words_exp++;
        if (stage.size() == BURST) push_exp(BURST);
        upd_empty();
    endtask

    // Monitor on the falling edge, then service the FIFO just after the rising edge.
    task automatic tick();
        burst_t b;
        @(negedge rclk);
        req_seen = rreq & rrst_n;
        if (rrst_n) begin
            if (rempty) chk("no_rreq_when_empty", rreq, 0);
            if (rreq) rreq_cnt++;
            if (burst_valid) valid_cnt++;
            if (prev_hold && burst_valid) chk("burst_stable", burst_data, prev_data);
            if (burst_valid && burst_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_burst", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("burst_data", burst_data, b.data);
                    chk("burst_cnt", burst_cnt, b.cnt);
                end
            end
            prev_hold = burst_valid && !burst_ready;
            prev_data = burst_data;
        end
        @(posedge rclk);
        #1;
        if (req_seen) begin
            if (fifo_q.size() == 0) chk("read_from_empty", 1, 0);
            else rdata = fifo_q.pop_front();
        end
        upd_empty();
    endtask

    task automatic wait_drain(input int max);
        for (int i = 0; i < max && (exp_q.size() != 0 || fifo_q.size() != 0); i++) tick();
        repeat (3) tick();
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #1;
        chk("rst_rreq", rreq, 0);
        chk("rst_valid", burst_valid, 0);
        chk("rst_cnt", burst_cnt, 0);
        chk("rst_data", burst_data, 0);
        chk("rst_words", words_read, 0);
        chk("rst_busy", busy, 0);
        repeat (2) tick();
        rrst_n = 1'b1;
        tick();

        // single burst with ready held high
        enable = 1'b1;
        burst_ready = 1'b1;
        rreq_cnt = 0;
        valid_cnt = 0;
        for (int v = 1; v <= 4; v++) push_word(DSIZE'(v));
        wait_drain(50);
        chk("t1_rreq_cycles", rreq_cnt, 4);
        chk("t1_valid_cycles", valid_cnt, 1);
        chk("t1_words", words_read, 16'(words_exp));

        // backpressure: exactly one burst gathered, then held
        burst_ready = 1'b0;
        rreq_cnt = 0;
        for (int v = 1; v <= 8; v++) push_word(DSIZE'(v));
        repeat (30) tick();
        chk("t2_rreq_cycles", rreq_cnt, 4);
        chk("t2_rreq_low", rreq, 0);
        chk("t2_valid_held", burst_valid, 1);
        chk("t2_burst_held", burst_data, exp_q[0].data);
        burst_ready = 1'b1;
        wait_drain(50);
        chk("t2_words", words_read, 16'(words_exp));

        // rempty toggling every cycle
        for (int v = 5; v <= 8; v++) push_word(DSIZE'(v));
        for (int i = 0; i < 100 && (exp_q.size() != 0 || fifo_q.size() != 0); i++) begin
            empty_mask = ~empty_mask;
            upd_empty();
            tick();
        end
        empty_mask = 1'b0;
        upd_empty();
        wait_drain(20);
        chk("t3_words", words_read, 16'(words_exp));

        // lone word: partial burst
        push_word(DSIZE'(9));
        for (int i = 0; i < 20 && words_read != 16'(words_exp); i++) tick();
        chk("t4_captured", words_read, 16'(words_exp));
`ifdef FIFO_BURST_TIMEOUT_EN
        begin
            int n = 0;
            push_exp(stage.size());
            while (!burst_valid && n < 200) begin
                tick();
                n++;
            end
            chk("t4_timeout_cycles", n, TIMEOUT);
            wait_drain(20);
        end
`else
        valid_cnt = 0;
        repeat (200) tick();
        chk("t4_no_flush", valid_cnt, 0);
        for (int v = 10; v <= 12; v++) push_word(DSIZE'(v));
        wait_drain(50);
`endif
        chk("t4_words", words_read, 16'(words_exp));

        // reset mid-burst discards the partial
        push_word(DSIZE'(20));
        push_word(DSIZE'(21));
        for (int i = 0; i < 20 && words_read != 16'(words_exp); i++) tick();
        chk("t5_pre_rst_words", words_read, 16'(words_exp));
        rrst_n = 1'b0;
        #1;
        chk("t5_rst_rreq", rreq, 0);
        chk("t5_rst_valid", burst_valid, 0);
        chk("t5_rst_cnt", burst_cnt, 0);
        chk("t5_rst_data", burst_data, 0);
        chk("t5_rst_words", words_read, 0);
        chk("t5_rst_busy", busy, 0);
        stage.delete();
        words_exp = 0;
        for (int v = 30; v <= 33; v++) push_word(DSIZE'(v));
        repeat (2) tick();
        rrst_n = 1'b1;
        @(negedge rclk);
        chk("t5_no_rreq_after_rel", rreq, 0);
        wait_drain(50);
        chk("t5_words", words_read, 16'(words_exp));

        chk("final_scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
